// File: rtl/dither_quantizer_if.sv
// Pixel stream bundle for dither_quantizer: 8-bit RGB in, BGR555 out.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high; the source holds its data stable until then.
interface dither_quantizer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [7:0]  in_r;
  logic [7:0]  in_g;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_pixel;
  logic        out_eol;
  logic        out_eof;

  modport master (
    output in_valid, in_sof, in_r, in_g, in_b, out_ready,
    input  in_ready, out_valid, out_pixel, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_sof, in_r, in_g, in_b, out_ready,
    output in_ready, out_valid, out_pixel, out_eol, out_eof
  );
endinterface

// File: rtl/dither_quantizer.sv
// Ordered-dither quantizer: 8-bit RGB to BGR555 with a 2x4 threshold matrix,
// tracking screen position internally; two-stage valid/ready pipeline.
module dither_quantizer #(
  parameter int LINE_WIDTH = 200,
  parameter int LINE_COUNT = 160
) (
  input logic               clock,
  input logic               reset,
  input logic               dither_enable,
  dither_quantizer_if.slave bus
);
  localparam int XW = $clog2(LINE_WIDTH);
  localparam int YW = $clog2(LINE_COUNT);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(LINE_COUNT - 1);

  logic [XW-1:0] r_pos_x;
  logic [YW-1:0] r_pos_y;
  logic          r_s1_valid;
  logic [7:0]    r_s1_r;
  logic [7:0]    r_s1_g;
  logic [7:0]    r_s1_b;
  logic [2:0]    r_s1_thr;
  logic          r_s1_eol;
  logic          r_s1_eof;
  logic          r_out_valid;
  logic [14:0]   r_out_pixel;
  logic          r_out_eol;
  logic          r_out_eof;

  logic          w_adv1;
  logic          w_adv2;
  logic          w_accept;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic [2:0]    w_thr;
  logic          w_eol;
  logic          w_eof;

  function automatic logic [2:0] thr_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd0;
      3'd1:    return 3'd4;
      3'd2:    return 3'd2;
      3'd3:    return 3'd6;
      3'd4:    return 3'd3;
      3'd5:    return 3'd7;
      3'd6:    return 3'd1;
      default: return 3'd5;
    endcase
  endfunction

  // Bit 8 of the sum is the overflow; saturating to 255 then keeping [7:3] gives 5'h1F.
  function automatic logic [4:0] quant(input logic [7:0] c, input logic [2:0] t);
    logic [8:0] sum;
    sum = {1'b0, c} + {6'd0, t};
    return sum[8] ? 5'h1F : sum[7:3];
  endfunction

  assign w_adv2       = !r_out_valid | bus.out_ready;
  assign w_adv1       = !r_s1_valid | w_adv2;
  assign bus.in_ready = w_adv1 & !reset;
  assign w_accept     = bus.in_valid & bus.in_ready;

  // in_sof re-homes the accepted pixel; counters then continue from (0,0).
  always_comb begin
    w_x     = bus.in_sof ? '0 : r_pos_x;
    w_y     = bus.in_sof ? '0 : r_pos_y;
    w_thr   = dither_enable ? thr_lut({w_y[1:0], w_x[0]}) : 3'd0;
    w_eol   = (w_x == X_LAST);
    w_eof   = w_eol && (w_y == Y_LAST);
    w_x_nxt = w_eol ? '0 : w_x + 1'b1;
    w_y_nxt = w_y;
    if (w_eol) begin
      w_y_nxt = (w_y == Y_LAST) ? '0 : w_y + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_r      <= '0;
      r_s1_g      <= '0;
      r_s1_b      <= '0;
      r_s1_thr    <= '0;
      r_s1_eol    <= 1'b0;
      r_s1_eof    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pos_x  <= w_x_nxt;
        r_pos_y  <= w_y_nxt;
        r_s1_r   <= bus.in_r;
        r_s1_g   <= bus.in_g;
        r_s1_b   <= bus.in_b;
        r_s1_thr <= w_thr;
        r_s1_eol <= w_eol;
        r_s1_eof <= w_eof;
      end
      if (w_adv1) begin
        r_s1_valid <= w_accept;
      end
      if (w_adv2) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_pixel <= {quant(r_s1_b, r_s1_thr), quant(r_s1_g, r_s1_thr),
                          quant(r_s1_r, r_s1_thr)};
          r_out_eol   <= r_s1_eol;
          r_out_eof   <= r_s1_eof;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_pixel = r_out_pixel;
  assign bus.out_eol   = r_out_eol;
  assign bus.out_eof   = r_out_eof;
endmodule

// File: tb/tb_dither_quantizer.sv
// Bench for dither_quantizer on a 4x4 frame: position/threshold model feeds
// an expected queue that is compared against every output word.
module tb_dither_quantizer;
  localparam int W = 4;
  localparam int H = 4;

  logic clk;
  logic rst;
  logic den;
  int   rdy_mode;
  int   n_checks;
  int   n_err;

  logic [16:0] exp_q[$];
  logic [16:0] hist[$];
  int          occ;
  int          mx;
  int          my;
  bit          rst_d;
  int          thr_tab[4][2];

  dither_quantizer_if dq ();

  dither_quantizer #(.LINE_WIDTH(W), .LINE_COUNT(H)) dut (
    .clock        (clk),
    .reset        (rst),
    .dither_enable(den),
    .bus          (dq.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] model_q(input int c, input int t);
    int s;
    s = c + t;
    if (s > 255) s = 255;
    return 5'(s / 8);
  endfunction

  // out_ready pattern: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    dq.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       dq.out_ready = 1'b1;
        1:       dq.out_ready = 1'($urandom_range(0, 1));
        default: dq.out_ready = 1'b0;
      endcase
    end
  end

  // scoreboard: compare head of queue every valid cycle, pop on handshake, push on accept
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      occ = 0;
      mx  = 0;
      my  = 0;
      check_eq("in_ready_in_reset", dq.in_ready, 0);
    end else begin
      if (rst_d) begin
        check_eq("rst_out_valid", dq.out_valid, 0);
        check_eq("rst_out_pixel", dq.out_pixel, 0);
        check_eq("rst_out_eol", dq.out_eol, 0);
        check_eq("rst_out_eof", dq.out_eof, 0);
      end
      check_eq("in_ready", dq.in_ready, (occ == 2 && !dq.out_ready) ? 0 : 1);
      if (dq.out_valid) begin
        check_eq("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check_eq("out_pixel", dq.out_pixel, exp_q[0][14:0]);
          check_eq("out_eol", dq.out_eol, exp_q[0][15]);
          check_eq("out_eof", dq.out_eof, exp_q[0][16]);
          if (dq.out_ready) begin
            hist.push_back({dq.out_eof, dq.out_eol, dq.out_pixel});
            void'(exp_q.pop_front());
            occ--;
          end
        end
      end
      if (dq.in_valid && dq.in_ready) begin
        int x;
        int y;
        int t;
        bit eol;
        bit eof;
        x   = dq.in_sof ? 0 : mx;
        y   = dq.in_sof ? 0 : my;
        t   = den ? thr_tab[y % 4][x % 2] : 0;
        eol = (x == W - 1);
        eof = eol && (y == H - 1);
        exp_q.push_back({eof, eol, model_q(dq.in_b, t), model_q(dq.in_g, t), model_q(dq.in_r, t)});
        occ++;
        mx = eol ? 0 : x + 1;
        my = eol ? ((y == H - 1) ? 0 : y + 1) : y;
      end
    end
    rst_d = rst;
  end

  // driver tasks
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit sof);
    bit acc;
    acc = 1'b0;
    dq.in_valid = 1'b1;
    dq.in_sof   = sof;
    dq.in_r     = r;
    dq.in_g     = g;
    dq.in_b     = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dq.in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    check_eq("accepted", acc, 1);
    @(posedge clk);
    #1;
    dq.in_valid = 1'b0;
    dq.in_sof   = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int n_eol;
    int n_eof;
    thr_tab     = '{'{0, 4}, '{2, 6}, '{3, 7}, '{1, 5}};
    n_checks    = 0;
    n_err       = 0;
    occ         = 0;
    mx          = 0;
    my          = 0;
    rst_d       = 1'b0;
    rdy_mode    = 0;
    rst         = 1'b1;
    den         = 1'b1;
    dq.in_valid = 1'b0;
    dq.in_sof   = 1'b0;
    dq.in_r     = '0;
    dq.in_g     = '0;
    dq.in_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // basic dither on 0x07: positions (0,0),(1,0),(2,0),(3,0),(0,1)
    base = hist.size();
    send(8'h07, 8'h07, 8'h07, 1'b1);
    for (int i = 0; i < 4; i++) send(8'h07, 8'h07, 8'h07, 1'b0);
    drain();
    check_eq("px00", hist[base][14:0], 15'h0000);
    check_eq("px10", hist[base+1][14:0], 15'h0421);
    check_eq("px01", hist[base+4][14:0], 15'h0421);

    // saturation at (1,2), then red 0xF8 at (1,0)
    send(8'h10, 8'h20, 8'h30, 1'b1);
    for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)), 8'h40, 8'h80, 1'b0);
    send(8'hFF, 8'hFF, 8'hFF, 1'b0);
    drain();
    check_eq("sat_7fff", hist[hist.size()-1][14:0], 15'h7FFF);
    send(8'h00, 8'h00, 8'h00, 1'b1);
    send(8'hF8, 8'h00, 8'h00, 1'b0);
    drain();
    check_eq("sat_001f", hist[hist.size()-1][14:0], 15'h001F);

    // dither disabled: eight 0x07 pixels all truncate to 0
    den  = 1'b0;
    base = hist.size();
    for (int i = 0; i < 8; i++) send(8'h07, 8'h07, 8'h07, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) check_eq("nodither", hist[base+i][14:0], 15'h0000);
    den = 1'b1;

    // full 4x4 frame plus wrap pixel
    base = hist.size();
    send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 1; i < 16; i++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    send(8'h07, 8'h07, 8'h07, 1'b0);
    drain();
    n_eol = 0;
    n_eof = 0;
    for (int i = 0; i < 16; i++) begin
      n_eol += int'(hist[base+i][15]);
      n_eof += int'(hist[base+i][16]);
    end
    check_eq("frame_eol_count", n_eol, 4);
    check_eq("frame_eof_count", n_eof, 1);
    check_eq("frame_eof_last", hist[base+15][16], 1);
    check_eq("frame_wrap_px", hist[base+16], 17'h00000);

    // random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 10; i++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // in_sof on the third pixel of a line
    base = hist.size();
    send(8'h07, 8'h07, 8'h07, 1'b1);
    send(8'h07, 8'h07, 8'h07, 1'b0);
    send(8'h07, 8'h07, 8'h07, 1'b1);
    send(8'h07, 8'h07, 8'h07, 1'b0);
    drain();
    check_eq("rehome_thr0", hist[base+2][14:0], 15'h0000);
    check_eq("rehome_next", hist[base+3][14:0], 15'h0421);

    // reset with two pixels in flight, then first pixel without sof is (0,0)
    send(8'h07, 8'h07, 8'h07, 1'b1);
    drain();
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send(8'h07, 8'h07, 8'h07, 1'b0);
    send(8'h07, 8'h07, 8'h07, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_mode = 0;
    base     = hist.size();
    send(8'h07, 8'h07, 8'h07, 1'b0);
    send(8'h07, 8'h07, 8'h07, 1'b0);
    drain();
    check_eq("post_rst_count", hist.size() - base, 2);
    check_eq("post_rst_px00", hist[base][14:0], 15'h0000);
    check_eq("post_rst_px10", hist[base+1][14:0], 15'h0421);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
